// File: rtl/mux_arb_if.sv
// Handshake/bus bundle between a multi-channel source and the mux_arb output stage.
// The master side drives channel data and downstream ready; the slave side is the arbiter.
interface mux_arb_if #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
);
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [N-1:0]         in_valid;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_ready;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/mux_arb.sv
// N-channel multiplexer with directed-select or round-robin grant feeding a
// single registered output stage with valid/ready back-pressure.
module mux_arb #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic     clk,
    input  logic     rst_n,
    mux_arb_if.slave bus
);
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic             can_accept_s;
    logic             grant_vld_s;
    logic [SELW-1:0]  grant_s;
    logic [SELW-1:0]  cand_s;
    logic             xfer_s;
    logic [N-1:0]     in_ready_s;

    assign can_accept_s = !out_valid_q || bus.out_ready;

    // Grant selection; the RR scan runs from farthest to nearest so the nearest valid wins.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_s     = '0;
        cand_s      = '0;
        if (bus.mode == 1'b0) begin
            if (int'(bus.sel) < N) begin
                grant_vld_s = 1'b1;
                grant_s     = bus.sel;
            end else begin
                grant_vld_s = 1'b0;
            end
        end else begin
            for (int k = N; k >= 1; k--) begin
                cand_s = SELW'((int'(ptr_q) + k) % N);
                if (bus.in_valid[cand_s]) begin
                    grant_vld_s = 1'b1;
                    grant_s     = cand_s;
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end
    end

    assign xfer_s = rst_n && grant_vld_s && can_accept_s && bus.in_valid[grant_s];

    // One-hot accept toward the granted channel only.
    always_comb begin
        in_ready_s = '0;
        for (int i = 0; i < N; i++) begin
            if (rst_n && can_accept_s && grant_vld_s && (grant_s == SELW'(i))) begin
                in_ready_s[i] = 1'b1;
            end else begin
                in_ready_s[i] = 1'b0;
            end
        end
    end

    // Output-stage next state: load wins over drain, and a stalled word is never overwritten.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data[int'(grant_s) * WIDTH +: WIDTH];
            out_ch_d    = grant_s;
            ptr_d       = grant_s;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; ptr resets to N-1 so channel 0 has first round-robin priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= SELW'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench for mux_arb: a transaction-level model predicts grants and pushes
// expected output words; a negedge monitor pops them as the DUT delivers.
module tb_mux_arb;
    localparam int WIDTH = 16;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic clk;
    logic rst_n;

    mux_arb_if #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) bus ();
    mux_arb_if #(.WIDTH(WIDTH), .N(3), .SELW(2))    bus3 ();

    mux_arb #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    mux_arb #(.WIDTH(WIDTH), .N(3), .SELW(2)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [SELW+WIDTH-1:0] exp_q[$];
    logic                  m_ov  = 1'b0;
    int                    m_ptr = N - 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive, predict and check at negedge, advance past the posedge.
    task automatic step(input logic rn, input logic m, input logic [SELW-1:0] s,
                        input logic [N-1:0] v, input logic [N*WIDTH-1:0] d, input logic ordy);
        int g;
        logic can;
        logic [N-1:0] exp_rdy;
        rst_n         = rn;
        bus.mode      = m;
        bus.sel       = s;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        @(negedge clk);
        g = -1;
        if (!m) begin
            if (int'(s) < N) g = int'(s);
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        can = !m_ov || ordy;
        exp_rdy = (rn && can && g >= 0) ? N'(1 << g) : '0;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        if (!rn) begin
            m_ov  = 1'b0;
            m_ptr = N - 1;
            exp_q.delete();
        end else if (g >= 0 && can && v[g]) begin
            exp_q.push_back({SELW'(g), d[g*WIDTH +: WIDTH]});
            m_ptr = g;
            m_ov  = 1'b1;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every word accepted downstream must match the oldest predicted word.
    always @(negedge clk) begin
        logic [SELW+WIDTH-1:0] w;
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(bus.out_data), 32'hDEAD_BEEF);
            end else begin
                w = exp_q.pop_front();
                chk("sb_out_data", 32'(bus.out_data), 32'(w[WIDTH-1:0]));
                chk("sb_out_ch", 32'(bus.out_ch), 32'(w[SELW+WIDTH-1:WIDTH]));
            end
        end
    end

    initial begin
        logic [N*WIDTH-1:0] dat;
        logic [N*WIDTH-1:0] rdat;
        int exp_seq[5];
        exp_seq = '{0, 1, 2, 3, 0};
        dat = {16'h1234, 16'h003F, 16'h01FF, 16'h00FF};

        bus3.mode = 1'b0; bus3.sel = 2'd0; bus3.in_valid = 3'b000;
        bus3.in_data = '0; bus3.out_ready = 1'b1;
        bus.mode = 1'b0; bus.sel = '0; bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        step(1'b0, 1'b0, 2'd2, 4'hF, dat, 1'b1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);

        // Directed select of channel 2
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 2'd2, 4'hF, dat, 1'b1);
            chk("dir_out_data", 32'(bus.out_data), 32'h003F);
            chk("dir_out_ch", 32'(bus.out_ch), 32'd2);
            chk("dir_in_ready", 32'(bus.in_ready), 32'b0100);
        end

        // Round-robin from reset
        step(1'b0, 1'b1, 2'd0, 4'hF, dat, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 2'd0, 4'hF, dat, 1'b1);
            chk("rr_out_ch", 32'(bus.out_ch), 32'(exp_seq[i]));
            chk("rr_out_valid", 32'(bus.out_valid), 32'd1);
        end

        // Stall holds the captured word from channel 1
        step(1'b1, 1'b1, 2'd0, 4'b0010, {16'h4444, 16'h3333, 16'h00AA, 16'h1111}, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 2'd0, 4'hF, {16'h4444, 16'h3333, 16'h5555, 16'h1111}, 1'b0);
            chk("stall_out_data", 32'(bus.out_data), 32'h00AA);
            chk("stall_out_ch", 32'(bus.out_ch), 32'd1);
        end
        step(1'b1, 1'b1, 2'd0, 4'hF, {16'h4444, 16'h3333, 16'h5555, 16'h1111}, 1'b1);
        chk("unstall_out_ch", 32'(bus.out_ch), 32'd2);
        chk("unstall_out_data", 32'(bus.out_data), 32'h3333);

        // Out-of-range select on the 3-channel instance
        bus3.in_valid = 3'b111; bus3.in_data = {16'hC3C3, 16'hB2B2, 16'hA1A1}; bus3.sel = 2'd0;
        step(1'b1, 1'b0, 2'd0, 4'h0, dat, 1'b1);
        chk("n3_load_valid", 32'(bus3.out_valid), 32'd1);
        chk("n3_load_data", 32'(bus3.out_data), 32'hA1A1);
        bus3.sel = 2'd3;
        step(1'b1, 1'b0, 2'd0, 4'h0, dat, 1'b1);
        chk("n3_sel3_in_ready", 32'(bus3.in_ready), 32'd0);
        chk("n3_drain_valid", 32'(bus3.out_valid), 32'd0);
        bus3.in_valid = 3'b000;

        // Reset while a stalled word is held
        step(1'b1, 1'b1, 2'd0, 4'b0100, dat, 1'b1);
        step(1'b1, 1'b1, 2'd0, 4'b0000, dat, 1'b0);
        chk("hold_before_rst", 32'(bus.out_valid), 32'd1);
        step(1'b0, 1'b1, 2'd0, 4'b0000, dat, 1'b0);
        chk("rst_discard_valid", 32'(bus.out_valid), 32'd0);
        step(1'b1, 1'b1, 2'd0, 4'hF, dat, 1'b1);
        chk("rst_rr_first_ch0", 32'(bus.out_ch), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < N; c++) rdat[c*WIDTH +: WIDTH] = WIDTH'($urandom);
            step(($urandom_range(0, 49) != 0), 1'($urandom), SELW'($urandom),
                 N'($urandom), rdat, ($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0, 4'h0, dat, 1'b1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
